// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings and the default flush word.
// Decode's unit_control imports the same encodings so both ends agree.
package fetch_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] PCSRC_SEQ    = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_JREG   = 3'b011;
    localparam logic [2:0] PCSRC_RET    = 3'b100;

    localparam logic [DATA_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Any select that leaves the sequential path discards the word fetched this cycle.
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == PCSRC_BRANCH) || (sel == PCSRC_JUMP) ||
               (sel == PCSRC_JREG)   || (sel == PCSRC_RET);
    endfunction

endpackage

// File: rtl/fetch_stage_return_stack.sv
// Hardware return-address stack: LIFO of return addresses with sticky
// overflow/underflow flags. Contents are not reset; only the pointer and flags are.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
    localparam logic [AW-1:0]  IDX_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             push_eff;
    logic             pop_eff;
    logic             swap_eff;

    assign full    = (sp == SP_FULL);
    assign empty   = (sp == '0);
    assign wr_idx  = sp[AW-1:0];
    assign top_idx = sp[AW-1:0] - IDX_ONE;
    assign top     = mem[top_idx];

    // A simultaneous push+pop on an empty stack degrades to a plain push.
    assign push_eff = en && push && (!pop || empty) && !full;
    assign pop_eff  = en && pop && !push && !empty;
    assign swap_eff = en && push && pop && !empty;

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_idx] <= push_data;
        end else if (swap_eff) begin
            mem[top_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            if (push_eff) begin
                sp <= sp + SP_ONE;
            end else if (pop_eff) begin
                sp <= sp - SP_ONE;
            end
            if (push && !pop && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC from decode's select,
// keeps the return-address stack and registers the IF/ID word for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pcSrc,
    input  logic        PCWrite,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_jpc,
    input  logic [31:0] reg_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    logic [31:0] pc_p0;
    logic [31:0] seq_p0;
    logic [31:0] next_pc_p0;
    logic [31:0] ret_target_p0;
    logic        redirect_p0;
    logic [31:0] instr_p1;
    logic [31:0] pc_plus4_p1;

    logic [31:0] ras_top;
    logic        ras_full;
    logic        ras_empty;

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (32)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .en        (PCWrite),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus4_p1),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // ---- stage p0: PC and next-PC selection ----
    assign seq_p0        = pc_p0 + 32'd4;
    assign ret_target_p0 = ras_empty ? seq_p0 : ras_top;
    assign redirect_p0   = PCWrite && is_redirect(pcSrc);

    always_comb begin
        next_pc_p0 = seq_p0;
        case (pcSrc)
            PCSRC_BRANCH: next_pc_p0 = branch_target;
            PCSRC_JUMP:   next_pc_p0 = jump_jpc;
            PCSRC_JREG:   next_pc_p0 = reg_target;
            PCSRC_RET:    next_pc_p0 = ret_target_p0;
            default:      next_pc_p0 = seq_p0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0 <= RESET_PC;
        end else if (PCWrite) begin
            pc_p0 <= next_pc_p0;
        end
    end

    // ---- stage p1: IF/ID register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1    <= NOP_WORD;
            pc_plus4_p1 <= 32'h0;
        end else if (PCWrite) begin
            instr_p1    <= redirect_p0 ? NOP_WORD : imem_data;
            pc_plus4_p1 <= seq_p0;
        end
    end

    assign imem_addr   = pc_p0;
    assign pc          = pc_p0;
    assign instruction = instr_p1;
    assign pc_plus4    = pc_plus4_p1;

    stack_state_sane: assert property (@(posedge clk) disable iff (rst) !(ras_full && ras_empty));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the program counter and selects the next PC from the decode stage's pcSrc, branch and jump targets.
- Holds a hardware return-address stack driven by the decoder's push_out/pop_out.
- Drives the instruction memory address and registers the IF/ID pipeline word (instruction + PC+4) consumed by decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 8, return-address stack entries (power of two, 2..32).
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pcSrc  in  3  next-PC select from decode.
- PCWrite  in  1  1 = advance; 0 = stall PC and IF/ID.
- push  in  1  push return address (decode's push_out).
- pop  in  1  pop return address (decode's pop_out).
- branch_target  in  32  branch target computed downstream.
- jump_jpc  in  32  jump target from decode.
- reg_target  in  32  register-indirect target (readData1).
- imem_addr  out  32  instruction memory address (= pc).
- imem_data  in  32  instruction word; combinational read of imem_addr.
- instruction  out  32  IF/ID instruction register, feeds decode.
- pc_plus4  out  32  IF/ID PC+4 register.
- pc  out  32  current PC.
- ras_overflow  out  1  sticky: push attempted while full.
- ras_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset values:
  - pc = RESET_PC; instruction = NOP_WORD; pc_plus4 = 0.
  - Stack pointer = 0 (empty); both sticky flags = 0.
  - Stack contents are don't-care.
- Reset wins over all other inputs in the same cycle.
- imem_addr = pc (combinational). The word at pc appears on instruction one cycle later.
- seq = pc + 4, modulo 2^32; wrap-around allowed.
- pcSrc decode and next PC:
  - 000: seq
  - 001: branch_target
  - 010: jump_jpc
  - 011: reg_target
  - 100: RAS top (pop)
  - 101..111: treated as 000.
- redirect = PCWrite & (pcSrc in 001..100).
- When PCWrite=1:
  - pc <= selected next PC.
  - pc_plus4 <= seq.
  - instruction <= NOP_WORD if redirect, else imem_data (flushes the wrong-path fetch).
- When PCWrite=0:
  - pc, instruction and pc_plus4 hold.
  - push, pop and pcSrc are ignored; the stack is unchanged.
  - Decode re-presents its controls when the stall releases.
- Return stack push (PCWrite=1, push=1, pop=0):
  - Writes the current pc_plus4 register value (return address of the instruction in decode) at sp; sp <= sp+1.
  - If full (sp == RAS_DEPTH): no write, sp holds, ras_overflow <= 1.
- Return stack pop (PCWrite=1, pop=1, push=0):
  - Target = entry[sp-1]; sp <= sp-1.
  - If empty: target = seq, sp holds, ras_underflow <= 1.
  - The pcSrc=100 select uses this target.
  - pop=1 with pcSrc≠100: sp still decrements; PC follows pcSrc.
- Simultaneous push and pop (PCWrite=1):
  - Non-empty: target = old entry[sp-1]; entry[sp-1] <= pc_plus4; sp unchanged.
  - Empty: treated as push only, target = seq, ras_underflow <= 1.
- Sticky flags clear only on rst.
- The stage adds no back-pressure of its own; stalls come only from PCWrite.

Decomposition:
- Shared package:
  - PCSRC_SEQ/BRANCH/JUMP/JREG/RET encodings (3-bit).
  - NOP_WORD default.
  - Shared with unit_control so both ends agree.
- One natural sub-module: return_stack.
  - Parameterised depth/width.
  - push/pop/push-data inputs; top, full and empty outputs; overflow/underflow flags.
- The PC mux and IF/ID register stay in fetch_stage.

Test Plan:
- Reset then 3 cycles, PCWrite=1, pcSrc=000, imem returns 32'hA0+addr:
  - pc steps 0,4,8,C.
  - instruction = 0 (NOP), A0, A4.
  - pc_plus4 = 0, 4, 8 (values after reset and each clock, aligned with instruction).
- Jump: pc=0x10, pcSrc=010, jump_jpc=0x400 → pc=0x400 and instruction=NOP next cycle; the cycle after that, instruction=imem[0x400].
- Stall: PCWrite=0 for 2 cycles with pcSrc=001, push=1 → pc, instruction, pc_plus4 and stack all unchanged; resumes with the redirect once PCWrite=1.
- Call/return: push with pc_plus4=0x24, later pop with pcSrc=100 → pc=0x24; a further pop on empty → pc=seq and ras_underflow=1.
- Fill RAS_DEPTH=8 pushes, then a 9th → ras_overflow=1, sp=8; 8 pops return values in LIFO order.
- Push+pop same cycle with top=0x50, pc_plus4=0x80 → pc=0x50, new top=0x80, depth unchanged. Also: rst asserted mid-stall → pc=RESET_PC, flags cleared.
